ddr_burst_master: RTL and testbench
===================================

DDR_BURST_MASTER -- requirements
Module: ddr_burst_master

Interface
REQ-001 SHALL have parameter ADDR_STRIDE, default 8, app_addr increment per command (2 beats x 4 address units).
REQ-002 SHALL have parameter LEN_W, default 16, width of burst_len.
REQ-003 SHALL have port clk, input, 1, single clock for all logic (200 MHz DDR reference domain).
REQ-004 SHALL have port rst_n, input, 1, reset; one clock, reset is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a burst.
REQ-006 SHALL have port op, input, 1, 0 = write, 1 = read; sampled with start.
REQ-007 SHALL have port start_addr, input, 29, first app address; sampled with start.
REQ-008 SHALL have port burst_len, input, LEN_W, number of 2-beat commands; sampled with start.
REQ-009 SHALL have port busy, output, 1, high from accepted start until the done pulse.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port wr_data_req, output, 1, pops one write word from the user's first-word-fall-through source.
REQ-012 SHALL have port wr_data_in, input, 256, write word, valid in the same cycle as wr_data_req.
REQ-013 SHALL have port rd_data_out, output, 256, read word to the user.
REQ-014 SHALL have port rd_data_valid, output, 1, qualifies rd_data_out.
REQ-015 SHALL have ports app_cmd (output, 3; 000 write, 001 read), app_en (output, 1), app_addr (output, 29), app_wdf_data (output, 256).
REQ-016 SHALL have ports app_rdy, app_wdf_rdy, phy_init_done (inputs, 1), app_rd_data (input, 256), app_rd_data_valid (input, 1).

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, BEAT1, RD_DRAIN, DONE.
REQ-018 IDLE SHALL accept start only when phy_init_done=1; start at any other time or state is ignored.
REQ-019 On acceptance SHALL latch op, start_addr, burst_len; go to DONE if burst_len=0 (no app_en), else ISSUE.
REQ-020 ISSUE SHALL assert app_en=1 for exactly one cycle when app_rdy=1 and, for writes, app_wdf_rdy=1; otherwise hold app_en=0 and wait.
REQ-021 After the app_en cycle SHALL enter BEAT1 for one cycle with app_en=0, app_cmd and app_addr held unchanged.
REQ-022 app_en SHALL never be high in two consecutive cycles; one command per minimum two cycles.
REQ-023 For writes, wr_data_req SHALL be high in the app_en cycle and the BEAT1 cycle; app_wdf_data SHALL equal wr_data_in combinationally (beat0 then beat1).
REQ-024 For reads, wr_data_req SHALL stay 0; app_wdf_data SHALL be driven 0.
REQ-025 After BEAT1, app_addr SHALL advance by ADDR_STRIDE modulo 2^29 (wraps 0x1FFFFFF8 -> 0x00000000).
REQ-026 After BEAT1 of the last command: writes go to DONE; reads go to RD_DRAIN.
REQ-027 rd_data_out/rd_data_valid SHALL be registered copies of app_rd_data/app_rd_data_valid (1-cycle latency) while busy; app_rd_data_valid outside busy SHALL be ignored.
REQ-028 SHALL count received read beats; RD_DRAIN exits to DONE once count = 2*burst_len (count width LEN_W+1).
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE; busy deasserts in that same cycle.
REQ-030 app_cmd SHALL read 000 whenever idle.

Reset
REQ-031 While rst_n=0: state IDLE; busy, done, app_en, wr_data_req, rd_data_valid = 0; app_cmd=000; app_addr, app_wdf_data, rd_data_out = 0; counters cleared.
REQ-032 Reset asserted mid-burst SHALL abort immediately with no done pulse; post-reset operation needs a new start.

Verification
REQ-033 Write, start_addr=0x100, burst_len=3 -> app_en high on 3 non-adjacent cycles at 0x100, 0x108, 0x110; 6 wr_data_req pulses; done once.
REQ-034 Read after REQ-033, same address/length, against the DDR simulation memory model -> 6 rd_data_valid beats matching written words in order; done after the 6th.
REQ-035 app_rdy low 5 cycles during ISSUE -> app_en held 0 for those cycles, no wr_data_req, burst completes afterward unchanged.
REQ-036 start with phy_init_done=0, and burst_len=0 after init -> first ignored (busy stays 0); second gives done one cycle after start, no app_en.
REQ-037 start_addr=0x1FFFFFF8, burst_len=2 -> second command at 0x00000000.
REQ-038 rst_n low mid-read with beats outstanding -> all outputs at reset values; late app_rd_data_valid ignored; no done.

Source files
------------

// File: rtl/ddr_burst_master.sv
// ddr_burst_master: issues 2-beat DDR app-port commands for a burst
// of burst_len commands, streaming write data or collecting read data.
//
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   start/op/start_addr/
//   burst_len             : burst request, sampled together with start
//   busy, done            : burst in flight / one-cycle completion pulse
//   wr_data_req/wr_data_in: pop strobe and head word of a FWFT source
//   rd_data_out/valid     : registered read words back to the user
//   app_*                 : MIG-style application command port
//   phy_init_done         : calibration finished, bursts allowed
module ddr_burst_master #(
  parameter int ADDR_STRIDE = 8,
  parameter int LEN_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [28:0]      start_addr,
  input  logic [LEN_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic             wr_data_req,
  input  logic [255:0]     wr_data_in,
  output logic [255:0]     rd_data_out,
  output logic             rd_data_valid,
  output logic [2:0]       app_cmd,
  output logic             app_en,
  output logic [28:0]      app_addr,
  output logic [255:0]     app_wdf_data,
  input  logic             app_rdy,
  input  logic             app_wdf_rdy,
  input  logic             phy_init_done,
  input  logic [255:0]     app_rd_data,
  input  logic             app_rd_data_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BEAT1,
    S_RD_DRAIN,
    S_DONE
  } state_e;

  localparam logic [28:0] STRIDE = 29'(ADDR_STRIDE);

  state_e state_q, state_d;

  logic             op_q, op_d;
  logic [28:0]      addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] left_q, left_d;
  logic [LEN_W:0]   rd_cnt_q, rd_cnt_d;
  logic [255:0]     rd_data_q;
  logic             rd_vld_q;

  logic accept;
  logic issue_ok;
  logic last_cmd;
  logic rd_all;
  logic rd_take;

  assign accept   = (state_q == S_IDLE)
                  & start & phy_init_done;
  // write commands also need room in the
  // write-data FIFO before they may go out
  assign issue_ok = app_rdy & (op_q | app_wdf_rdy);
  assign last_cmd = (left_q == LEN_W'(1));
  assign rd_all   = (rd_cnt_q == {len_q, 1'b0});
  // read returns only count while a burst
  // is in flight; strays are dropped
  assign rd_take  = busy & app_rd_data_valid;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (burst_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (issue_ok) begin
          state_d = S_BEAT1;
        end
      end
      S_BEAT1: begin
        if (!last_cmd) begin
          state_d = S_ISSUE;
        end else if (op_q) begin
          state_d = S_RD_DRAIN;
        end else begin
          state_d = S_DONE;
        end
      end
      S_RD_DRAIN: begin
        if (rd_all) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // output logic
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    app_en      = 1'b0;
    wr_data_req = 1'b0;
    app_cmd     = 3'b000;
    unique case (state_q)
      S_ISSUE: begin
        busy        = 1'b1;
        app_cmd     = {2'b00, op_q};
        app_en      = issue_ok;
        wr_data_req = issue_ok & ~op_q;
      end
      S_BEAT1: begin
        busy        = 1'b1;
        app_cmd     = {2'b00, op_q};
        wr_data_req = ~op_q;
      end
      S_RD_DRAIN: begin
        busy        = 1'b1;
        app_cmd     = {2'b00, op_q};
      end
      S_DONE: begin
        done        = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign app_wdf_data  = wr_data_req ? wr_data_in
                                     : '0;
  assign app_addr      = addr_q;
  assign rd_data_out   = rd_data_q;
  assign rd_data_valid = rd_vld_q;

  // burst bookkeeping
  always_comb begin
    op_d     = op_q;
    addr_d   = addr_q;
    len_d    = len_q;
    left_d   = left_q;
    rd_cnt_d = rd_cnt_q;
    if (accept) begin
      op_d     = op;
      addr_d   = start_addr;
      len_d    = burst_len;
      left_d   = burst_len;
      rd_cnt_d = '0;
    end else begin
      // address stays put through BEAT1 and
      // wraps naturally at 29 bits
      if (state_q == S_BEAT1) begin
        addr_d = addr_q + STRIDE;
        left_d = left_q - LEN_W'(1);
      end
      if (rd_take) begin
        rd_cnt_d = rd_cnt_q + (LEN_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      left_q    <= '0;
      rd_cnt_q  <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      op_q     <= op_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      left_q   <= left_d;
      rd_cnt_q <= rd_cnt_d;
      rd_vld_q <= rd_take;
      if (rd_take) begin
        rd_data_q <= app_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_ddr_burst_master.sv
// tb_ddr_burst_master: directed bursts against a small DDR memory
// model, with a per-cycle compare process and literal spot checks.
module tb_ddr_burst_master;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [28:0]  start_addr;
  logic [15:0]  burst_len;
  logic         busy;
  logic         done;
  logic         wr_data_req;
  logic [255:0] wr_data_in;
  logic [255:0] rd_data_out;
  logic         rd_data_valid;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic [28:0]  app_addr;
  logic [255:0] app_wdf_data;
  logic         app_rdy;
  logic         app_wdf_rdy;
  logic         phy_init_done;
  logic [255:0] app_rd_data;
  logic         app_rd_data_valid;

  always #5 clk = ~clk;

  ddr_burst_master #(
    .ADDR_STRIDE(8),
    .LEN_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .op(op),
    .start_addr(start_addr),
    .burst_len(burst_len),
    .busy(busy),
    .done(done),
    .wr_data_req(wr_data_req),
    .wr_data_in(wr_data_in),
    .rd_data_out(rd_data_out),
    .rd_data_valid(rd_data_valid),
    .app_cmd(app_cmd),
    .app_en(app_en),
    .app_addr(app_addr),
    .app_wdf_data(app_wdf_data),
    .app_rdy(app_rdy),
    .app_wdf_rdy(app_wdf_rdy),
    .phy_init_done(phy_init_done),
    .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input bit ok, input string nm,
                              input logic [255:0] act,
                              input logic [255:0] exp);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [255:0] word(input int k);
    return {8{32'hC0DE_0000 + 32'(k)}};
  endfunction

  // model state: written only by the compare process
  bit           prev_en;
  bit           inflight;
  bit           bflag;
  bit           cur_op;
  int           wr_idx;
  int           n_en, n_wrq, n_rdv, n_done, n_busy;
  int           done_cyc, last_rdv_cyc;
  logic [28:0]  addr_log[$];
  int           en_cyc[$];
  logic [28:0]  exp_addr[$];
  logic [255:0] exp_rd[$];
  logic [255:0] exp_mem0[int unsigned];
  logic [255:0] exp_mem1[int unsigned];
  logic [255:0] mem0[int unsigned];
  logic [255:0] mem1[int unsigned];
  logic [28:0]  last_wa;
  logic [255:0] rq_data[$];
  int           rq_due[$];

  always @(negedge clk) begin : cmp
    logic [28:0]  ea;
    logic [255:0] er;
    bit           ew;
    if (!rst_n) begin
      chk(!busy && !done && !app_en && !wr_data_req
          && !rd_data_valid && app_cmd == 3'b000
          && app_addr == '0 && app_wdf_data == '0
          && rd_data_out == '0, "reset_outputs",
          256'({busy, done, app_en, wr_data_req,
                rd_data_valid, app_cmd, |app_addr,
                |app_wdf_data, |rd_data_out}), '0);
      inflight = 0;
      bflag    = 0;
      exp_addr.delete();
      exp_rd.delete();
    end else begin
      if (busy) n_busy++;
      chk(busy == (bflag && !done), "busy",
          256'(busy), 256'(bflag && !done));
      if (app_en) begin
        n_en++;
        en_cyc.push_back(cyc);
        addr_log.push_back(app_addr);
        chk(!prev_en, "en_back_to_back", 1, 0);
        chk(app_rdy && (app_cmd[0] || app_wdf_rdy),
            "en_without_rdy", 256'({app_rdy, app_wdf_rdy}), 3);
        chk(app_cmd == {2'b00, cur_op}, "app_cmd",
            256'(app_cmd), 256'({2'b00, cur_op}));
        if (exp_addr.size() == 0) begin
          chk(0, "en_unexpected", 256'(app_addr), 0);
        end else begin
          ea = exp_addr.pop_front();
          chk(app_addr == ea, "app_addr",
              256'(app_addr), 256'(ea));
        end
      end
      ew = busy && !cur_op && (app_en || prev_en);
      chk(wr_data_req == ew, "wr_data_req",
          256'(wr_data_req), 256'(ew));
      if (wr_data_req) begin
        n_wrq++;
        chk(app_wdf_data == wr_data_in, "wdf_data",
            app_wdf_data, wr_data_in);
      end
      if (busy && cur_op)
        chk(app_wdf_data == '0, "wdf_read_zero",
            app_wdf_data, '0);
      if (!busy && !done)
        chk(app_cmd == 3'b000, "idle_cmd",
            256'(app_cmd), 0);
      if (rd_data_valid) begin
        n_rdv++;
        last_rdv_cyc = cyc;
        if (exp_rd.size() == 0) begin
          chk(0, "rd_unexpected", rd_data_out, '0);
        end else begin
          er = exp_rd.pop_front();
          chk(rd_data_out == er, "rd_data", rd_data_out, er);
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        chk(inflight, "done_unexpected", 1, 0);
        chk(exp_addr.size() == 0, "done_cmds_left",
            256'(exp_addr.size()), 0);
        chk(exp_rd.size() == 0, "done_beats_left",
            256'(exp_rd.size()), 0);
        inflight = 0;
        bflag    = 0;
      end
      // acceptance: start while calibrated and idle
      if (start && phy_init_done && !inflight) begin
        inflight = 1;
        bflag    = (burst_len != 0);
        cur_op   = op;
        for (int i = 0; i < int'(burst_len); i++) begin
          ea = start_addr + 29'(8 * i);
          exp_addr.push_back(ea);
          if (!op) begin
            exp_mem0[32'(ea)] = word(wr_idx + 2 * i);
            exp_mem1[32'(ea)] = word(wr_idx + 2 * i + 1);
          end else begin
            exp_rd.push_back(exp_mem0[32'(ea)]);
            exp_rd.push_back(exp_mem1[32'(ea)]);
          end
        end
      end
    end
    prev_en = rst_n && app_en;
    // DDR memory: commands/data accepted at the coming edge
    if (rst_n && app_en && app_rdy) begin
      if (app_cmd == 3'b000) begin
        mem0[32'(app_addr)] = app_wdf_data;
        last_wa = app_addr;
      end else begin
        rq_data.push_back(mem0[32'(app_addr)]);
        rq_due.push_back(cyc + 3);
        rq_data.push_back(mem1[32'(app_addr)]);
        rq_due.push_back(cyc + 4);
      end
    end else if (rst_n && wr_data_req) begin
      mem1[32'(last_wa)] = app_wdf_data;
    end
    // FWFT write source advances on each pop
    if (rst_n && wr_data_req) wr_idx++;
    wr_data_in = word(wr_idx);
    // read returns keep coming even across a reset
    if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
      app_rd_data_valid = 1'b1;
      app_rd_data = rq_data.pop_front();
      void'(rq_due.pop_front());
    end else begin
      app_rd_data_valid = 1'b0;
      app_rd_data = '0;
    end
  end

  int st_cyc;
  int s_en, s_wrq, s_rdv, s_done, s_busy, s_log;

  task automatic snap();
    s_en   = n_en;
    s_wrq  = n_wrq;
    s_rdv  = n_rdv;
    s_done = n_done;
    s_busy = n_busy;
    s_log  = addr_log.size();
  endtask

  task automatic start_burst(input bit o,
                             input logic [28:0] a,
                             input logic [15:0] l);
    start      = 1'b1;
    op         = o;
    start_addr = a;
    burst_len  = l;
    st_cyc     = cyc;
    @(posedge clk);
    #1;
    start      = 1'b0;
    op         = ~o;
    start_addr = '0;
    burst_len  = 16'hFFFF;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (n_done == s_done && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(n_done > s_done, "done_timeout", 256'(k), 256'(budget));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_addrs(input string nm,
                           input logic [28:0] a0,
                           input logic [28:0] a1);
    chk(addr_log[s_log] == a0, nm,
        256'(addr_log[s_log]), 256'(a0));
    chk(addr_log[s_log + 1] == a1, nm,
        256'(addr_log[s_log + 1]), 256'(a1));
  endtask

  initial begin
    int k;
    int r0;
    rst_n = 1'b0;
    start = 1'b0;
    op = 1'b0;
    start_addr = '0;
    burst_len = '0;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    phy_init_done = 1'b0;
    app_rd_data = '0;
    app_rd_data_valid = 1'b0;
    wr_data_in = word(0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // start before calibration is ignored
    snap();
    start_burst(1'b0, 29'h40, 16'd2);
    repeat (6) @(posedge clk);
    #1;
    chk(n_busy == s_busy, "noinit_busy", 256'(n_busy - s_busy), 0);
    chk(n_en == s_en, "noinit_en", 256'(n_en - s_en), 0);
    chk(n_done == s_done, "noinit_done", 256'(n_done - s_done), 0);
    phy_init_done = 1'b1;
    @(posedge clk);
    #1;

    // write 3 commands at 0x100
    snap();
    start_burst(1'b0, 29'h100, 16'd3);
    wait_done(60);
    chk(n_en - s_en == 3, "wr3_en_count", 256'(n_en - s_en), 3);
    chk_addrs("wr3_addr", 29'h100, 29'h108);
    chk(addr_log[s_log + 2] == 29'h110, "wr3_addr2",
        256'(addr_log[s_log + 2]), 256'h110);
    chk(n_wrq - s_wrq == 6, "wr3_req_count", 256'(n_wrq - s_wrq), 6);
    chk(n_done - s_done == 1, "wr3_done_count",
        256'(n_done - s_done), 1);
    chk(en_cyc[s_log + 1] - en_cyc[s_log] == 2, "wr3_en_spacing",
        256'(en_cyc[s_log + 1] - en_cyc[s_log]), 2);

    // read them back
    snap();
    start_burst(1'b1, 29'h100, 16'd3);
    wait_done(80);
    chk(n_rdv - s_rdv == 6, "rd3_beats", 256'(n_rdv - s_rdv), 6);
    chk(n_wrq == s_wrq, "rd3_no_wrq", 256'(n_wrq - s_wrq), 0);
    chk(done_cyc > last_rdv_cyc, "rd3_done_after_last",
        256'(done_cyc), 256'(last_rdv_cyc));
    chk(n_done - s_done == 1, "rd3_done_count",
        256'(n_done - s_done), 1);

    // app_rdy held low for 5 ISSUE cycles
    app_rdy = 1'b0;
    snap();
    start_burst(1'b0, 29'h200, 16'd2);
    repeat (5) @(posedge clk);
    #1;
    chk(n_wrq == s_wrq, "stall_no_wrq", 256'(n_wrq - s_wrq), 0);
    app_rdy = 1'b1;
    wait_done(60);
    chk(n_en - s_en == 2, "stall_en_count", 256'(n_en - s_en), 2);
    chk(en_cyc[s_log] == st_cyc + 6, "stall_first_en",
        256'(en_cyc[s_log]), 256'(st_cyc + 6));
    chk_addrs("stall_addr", 29'h200, 29'h208);
    chk(n_wrq - s_wrq == 4, "stall_wrq", 256'(n_wrq - s_wrq), 4);

    // zero-length burst
    snap();
    start_burst(1'b0, 29'h300, 16'd0);
    wait_done(10);
    chk(done_cyc == st_cyc + 1, "len0_done_cycle",
        256'(done_cyc), 256'(st_cyc + 1));
    chk(n_en == s_en, "len0_no_en", 256'(n_en - s_en), 0);
    chk(n_busy == s_busy, "len0_no_busy", 256'(n_busy - s_busy), 0);

    // address wrap at the top of the 29-bit space
    snap();
    start_burst(1'b0, 29'h1FFF_FFF8, 16'd2);
    wait_done(60);
    chk_addrs("wrap_addr", 29'h1FFF_FFF8, 29'h0);
    snap();
    start_burst(1'b1, 29'h1FFF_FFF8, 16'd2);
    wait_done(80);
    chk(n_rdv - s_rdv == 4, "wrap_rd_beats", 256'(n_rdv - s_rdv), 4);

    // reset in the middle of a read
    snap();
    start_burst(1'b1, 29'h100, 16'd3);
    k = 0;
    while (n_rdv - s_rdv < 2 && k < 60) begin
      @(posedge clk);
      k++;
    end
    chk(k < 60, "rst_wait_timeout", 256'(k), 60);
    #1;
    rst_n = 1'b0;
    r0 = n_rdv;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk(n_done == s_done, "rst_no_done", 256'(n_done - s_done), 0);
    chk(n_rdv == r0, "rst_late_beats", 256'(n_rdv - r0), 0);
    chk(!busy, "rst_busy_after", 256'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
